// File: rtl/ram_arbiter.sv
// Zero-fills the 64-entry scratch RAM after reset, then round-robin arbitrates A/B single-cycle accesses.
// Grant is same-cycle combinational, read data valid one cycle after grant; the loser simply holds its request.
module ram_arbiter #(
    parameter int BIT_WIDTH      = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 a_req,
    input  logic                 a_wren,
    input  logic [5:0]           a_addr,
    input  logic [BIT_WIDTH-1:0] a_data,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [BIT_WIDTH-1:0] a_q,
    input  logic                 b_req,
    input  logic                 b_wren,
    input  logic [5:0]           b_addr,
    input  logic [BIT_WIDTH-1:0] b_data,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [BIT_WIDTH-1:0] b_q,
    output logic [5:0]           ram_addr,
    output logic [BIT_WIDTH-1:0] ram_data,
    output logic                 ram_wren,
    input  logic [BIT_WIDTH-1:0] ram_q,
    output logic                 busy
);

    typedef enum logic {
        ST_CLEAR,
        ST_SERVE
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] clr_cnt_q, clr_cnt_d;
    logic       last_b_q, last_b_d;     // 1 = B held the most recent grant
    logic       a_rvalid_q, a_rvalid_d;
    logic       b_rvalid_q, b_rvalid_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        last_b_d  = last_b_q;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        ram_addr  = '0;
        ram_data  = '0;
        ram_wren  = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy      = 1'b1;
                ram_wren  = 1'b1;
                ram_addr  = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + 6'd1;
                if (clr_cnt_q == 6'd63) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                // Under contention the side that did not win last time goes first.
                a_gnt = a_req & (~b_req | last_b_q);
                b_gnt = b_req & (~a_req | ~last_b_q);
                if (a_gnt) begin
                    ram_addr = a_addr;
                    ram_data = a_data;
                    ram_wren = a_wren;
                    last_b_d = 1'b0;
                end else if (b_gnt) begin
                    ram_addr = b_addr;
                    ram_data = b_data;
                    ram_wren = b_wren;
                    last_b_d = 1'b1;
                end
            end
            default: state_d = ST_SERVE;
        endcase
        a_rvalid_d = a_gnt & ~a_wren;
        b_rvalid_d = b_gnt & ~b_wren;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;
            clr_cnt_q  <= 6'd0;
            last_b_q   <= 1'b1;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            last_b_q   <= last_b_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_q      = ram_q;
    assign b_q      = ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, vector table for grants, queue scoreboard for read returns.
module tb_ram_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       a_req, a_wren, b_req, b_wren;
    logic [5:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0] a_q, b_q;
    logic [5:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_wren;
    logic [7:0] ram_q;
    logic       busy;

    always #5 clock = ~clock;

    ram_arbiter #(.BIT_WIDTH(8), .CLEAR_ON_RESET(1'b1)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_wren(a_wren), .a_addr(a_addr), .a_data(a_data),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_q(a_q),
        .b_req(b_req), .b_wren(b_wren), .b_addr(b_addr), .b_data(b_data),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_q(b_q),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q), .busy(busy)
    );

    // Single-port RAM with registered read; contents start as non-zero garbage.
    logic [7:0] mem [64];
    bit         mem_filled = 1'b0;
    always @(posedge clock) begin
        if (!mem_filled) begin
            for (int i = 0; i < 64; i++) mem[i] = 8'hC3 ^ 8'(i);
            mem_filled = 1'b1;
        end
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    typedef struct {
        logic       a_req, a_wren;
        logic [5:0] a_addr;
        logic [7:0] a_data;
        logic       b_req, b_wren;
        logic [5:0] b_addr;
        logic [7:0] b_data;
        logic       exp_a_gnt, exp_b_gnt;
    } vec_t;

    typedef struct {
        int         due;
        bit         side_b;
        logic [7:0] data;
    } rd_t;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    rd_t        sb [$];
    logic [7:0] exp_mem [64];
    vec_t       vecs [$];

    function automatic vec_t mk(input logic ar, input logic aw, input logic [5:0] aa, input logic [7:0] ad,
                                input logic br, input logic bw, input logic [5:0] ba, input logic [7:0] bd,
                                input logic ea, input logic eb);
        vec_t v;
        v.a_req = ar; v.a_wren = aw; v.a_addr = aa; v.a_data = ad;
        v.b_req = br; v.b_wren = bw; v.b_addr = ba; v.b_data = bd;
        v.exp_a_gnt = ea; v.exp_b_gnt = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drive(input vec_t v);
        a_req = v.a_req; a_wren = v.a_wren; a_addr = v.a_addr; a_data = v.a_data;
        b_req = v.b_req; b_wren = v.b_wren; b_addr = v.b_addr; b_data = v.b_data;
    endtask

    // Grant check plus read-return scoreboard; called mid-cycle with inputs settled.
    task automatic sb_check(input logic ea, input logic eb);
        rd_t r;
        chk("a_gnt", {31'd0, a_gnt}, {31'd0, ea});
        chk("b_gnt", {31'd0, b_gnt}, {31'd0, eb});
        if (sb.size() > 0 && sb[0].due == cyc) begin
            r = sb.pop_front();
            chk("a_rvalid", {31'd0, a_rvalid}, {31'd0, !r.side_b});
            chk("b_rvalid", {31'd0, b_rvalid}, {31'd0, r.side_b});
            chk("rdata", {24'd0, (r.side_b ? b_q : a_q)}, {24'd0, r.data});
        end else begin
            chk("rvalid_idle", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        end
        if (ea) begin
            if (a_wren) exp_mem[a_addr] = a_data;
            else sb.push_back('{due: cyc + 1, side_b: 1'b0, data: exp_mem[a_addr]});
        end else if (eb) begin
            if (b_wren) exp_mem[b_addr] = b_data;
            else sb.push_back('{due: cyc + 1, side_b: 1'b1, data: exp_mem[b_addr]});
        end
    endtask

    task automatic run_clear(input int n);
        for (int k = 0; k < n; k++) begin
            #3;
            chk("clr_busy", {31'd0, busy}, 32'd1);
            chk("clr_addr", {26'd0, ram_addr}, k);
            chk("clr_wren", {31'd0, ram_wren}, 32'd1);
            chk("clr_data", {24'd0, ram_data}, 32'd0);
            sb_check(1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic apply(input vec_t v);
        drive(v);
        #3;
        sb_check(v.exp_a_gnt, v.exp_b_gnt);
        tick();
    endtask

    initial begin
        vec_t idle;
        idle = mk(1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) exp_mem[i] = 8'h00;

        // Reset and full clear while A keeps a read of addr 37 pending.
        drive(mk(1'b1, 1'b0, 6'd37, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0));
        reset = 1'b1;
        #1;
        tick();
        reset = 1'b0;
        run_clear(64);
        #3;
        chk("busy_after_clear", {31'd0, busy}, 32'd0);
        #1;
        sb_check(1'b1, 1'b0);
        tick();

        // After the addr-37 read A holds last grant.
        vecs.push_back(mk(1'b1, 1'b1, 6'd5,  8'hA5, 1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 6'd5,  8'h00, 1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 1'b1, 6'd37, 8'h77, 1'b0, 1'b1));
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(mk(1'b1, 1'b0, 6'd5, 8'h00, 1'b1, 1'b0, 6'd37, 8'h00, 1'b1, 1'b0));
            vecs.push_back(mk(1'b1, 1'b0, 6'd5, 8'h00, 1'b1, 1'b0, 6'd37, 8'h00, 1'b0, 1'b1));
        end
        vecs.push_back(mk(1'b1, 1'b1, 6'd63, 8'h3C, 1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 6'd63, 8'h00, 1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 1'b0));
        vecs.push_back(idle);
        vecs.push_back(mk(1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 1'b0, 6'd5,  8'h00, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 6'd9,  8'h11, 1'b1, 1'b1, 6'd10, 8'h22, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 6'd9,  8'h11, 1'b1, 1'b1, 6'd10, 8'h22, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 6'd10, 8'h00, 1'b1, 1'b0, 6'd9,  8'h00, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 6'd10, 8'h00, 1'b1, 1'b0, 6'd9,  8'h00, 1'b0, 1'b1));
        vecs.push_back(idle);
        vecs.push_back(idle);
        foreach (vecs[i]) apply(vecs[i]);

        // Reset mid-clear: the clear must restart from address 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_clear(20);
        #3;
        chk("midclr_addr", {26'd0, ram_addr}, 32'd20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_clear(64);
        for (int i = 0; i < 64; i++) exp_mem[i] = 8'h00;

        // Reset in the same cycle as an A read grant: its rvalid is dropped.
        drive(mk(1'b1, 1'b0, 6'd37, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0));
        reset = 1'b1;
        #3;
        chk("gnt_in_reset", {31'd0, a_gnt}, 32'd1);
        tick();
        reset = 1'b0;
        drive(idle);
        run_clear(64);
        // last_grant is back at B, so A wins the first contention.
        apply(mk(1'b1, 1'b0, 6'd1, 8'h00, 1'b1, 1'b0, 6'd2, 8'h00, 1'b1, 1'b0));
        apply(mk(1'b1, 1'b0, 6'd1, 8'h00, 1'b1, 1'b0, 6'd2, 8'h00, 1'b0, 1'b1));
        apply(idle);
        apply(idle);
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
